// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Brief    : Shared opcode encodings, instruction field positions and opcode
//             classification helpers for the 16-bit CPU pipeline.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Opcode encodings (instruction bits [15:12])
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SLL  = 4'h5;
    localparam logic [3:0] OP_SRL  = 4'h6;
    localparam logic [3:0] OP_ADDI = 4'h7;
    localparam logic [3:0] OP_LW   = 4'h8;
    localparam logic [3:0] OP_SW   = 4'h9;
    localparam logic [3:0] OP_LUI  = 4'hA;
    localparam logic [3:0] OP_BEQ  = 4'hB;
    localparam logic [3:0] OP_BNE  = 4'hC;
    localparam logic [3:0] OP_JMP  = 4'hD;
    localparam logic [3:0] OP_JR   = 4'hE;
    localparam logic [3:0] OP_NOP  = 4'hF;

    // Instruction field bit positions
    localparam int OP_HI    = 15;
    localparam int OP_LO    = 12;
    localparam int RD_HI    = 11;
    localparam int RD_LO    = 9;
    localparam int RS_HI    = 8;
    localparam int RS_LO    = 6;
    localparam int RT_HI    = 5;
    localparam int RT_LO    = 3;
    localparam int IMM6_HI  = 5;
    localparam int IMM9_HI  = 8;
    localparam int IMM12_HI = 11;

    // True when the opcode reads the rs register
    function automatic logic uses_rs(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL,
            OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_JR: uses_rs = 1'b1;
            default:                                      uses_rs = 1'b0;
        endcase
    endfunction

    // True when the opcode reads the rt register
    function automatic logic uses_rt(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL,
            OP_SW, OP_BEQ, OP_BNE: uses_rt = 1'b1;
            default:               uses_rt = 1'b0;
        endcase
    endfunction

    // True when the opcode produces a register result (before the rd=0 check)
    function automatic logic writes_reg(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL,
            OP_ADDI, OP_LW, OP_LUI: writes_reg = 1'b1;
            default:                writes_reg = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_stage_reg_file.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file
//  Brief    : NREGS x DW architectural register file, one write port and two
//             combinational read ports with write-through bypass; r0 reads 0.
//             Contents are intentionally not reset.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_file #(
    parameter int NREGS = 8,
    parameter int AW    = 3,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr_a,
    output logic [DW-1:0] o_rdata_a,
    input  logic [AW-1:0] i_raddr_b,
    output logic [DW-1:0] o_rdata_b
);

    logic [DW-1:0] r_mem [NREGS];

    // Writeback; r0 is never written so it stays a constant zero source
    always_ff @(posedge clk) begin
        if (i_we && (i_waddr != '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port A: r0 -> 0, same-cycle writeback wins over stored value
    always_comb begin
        if (i_raddr_a == '0) begin
            o_rdata_a = '0;
        end else if (i_we && (i_waddr == i_raddr_a)) begin
            o_rdata_a = i_wdata;
        end else begin
            o_rdata_a = r_mem[i_raddr_a];
        end
    end

    // Read port B: identical bypass rules to port A
    always_comb begin
        if (i_raddr_b == '0) begin
            o_rdata_b = '0;
        end else if (i_we && (i_waddr == i_raddr_b)) begin
            o_rdata_b = i_wdata;
        end else begin
            o_rdata_b = r_mem[i_raddr_b];
        end
    end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : decode_stage
//  Brief    : ID stage of the 16-bit CPU. Decodes the fetched instruction,
//             reads operands, detects load-use hazards (stalling fetch) and
//             holds the registered ID/EX bundle for the execute stage.
//  Revision : 1.0 - initial release
// ============================================================================
module decode_stage
    import cpu_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [15:0]   if_pc,
    input  logic [15:0]   if_inst,
    input  logic          if_inst_invalid,
    input  logic          flush,
    input  logic          ex_hold,
    input  logic [AW-1:0] ex_rd,
    input  logic          ex_is_load,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_addr,
    input  logic [15:0]   wb_data,
    output logic          stall_out,
    output logic          id_valid,
    output logic [15:0]   id_pc,
    output logic [3:0]    id_op,
    output logic [AW-1:0] id_rd,
    output logic [AW-1:0] id_rs,
    output logic [AW-1:0] id_rt,
    output logic [15:0]   id_rs_data,
    output logic [15:0]   id_rt_data,
    output logic [15:0]   id_imm,
    output logic          id_reg_write,
    output logic          id_mem_read,
    output logic          id_mem_write,
    output logic          id_branch,
    output logic          id_jump
);

    // Instruction fields
    logic [3:0]    w_op;
    logic [AW-1:0] w_rd;
    logic [AW-1:0] w_rs;
    logic [AW-1:0] w_rt;
    logic [15:0]   w_imm;
    logic [15:0]   w_rs_data;
    logic [15:0]   w_rt_data;
    logic          w_hazard;
    logic          w_slot_valid;
    logic          w_bubble;

    // ID/EX pipeline register
    logic          r_valid;
    logic [15:0]   r_pc;
    logic [3:0]    r_op;
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_rs;
    logic [AW-1:0] r_rt;
    logic [15:0]   r_rs_data;
    logic [15:0]   r_rt_data;
    logic [15:0]   r_imm;
    logic          r_reg_write;
    logic          r_mem_read;
    logic          r_mem_write;
    logic          r_branch;
    logic          r_jump;

    assign w_op = if_inst[OP_HI:OP_LO];
    assign w_rd = if_inst[RD_HI:RD_LO];
    assign w_rs = if_inst[RS_HI:RS_LO];
    assign w_rt = if_inst[RT_HI:RT_LO];

    reg_file #(
        .NREGS (NREGS),
        .AW    (AW),
        .DW    (16)
    ) u_reg_file (
        .clk       (clk),
        .i_we      (wb_we),
        .i_waddr   (wb_addr),
        .i_wdata   (wb_data),
        .i_raddr_a (w_rs),
        .o_rdata_a (w_rs_data),
        .i_raddr_b (w_rt),
        .o_rdata_b (w_rt_data)
    );

    // Immediate extension chosen by opcode class
    always_comb begin
        w_imm = '0;
        case (w_op)
            OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE:
                w_imm = {{10{if_inst[IMM6_HI]}}, if_inst[IMM6_HI:0]};
            OP_LUI:
                w_imm = {if_inst[IMM9_HI:0], 7'b0};
            OP_JMP:
                w_imm = {{4{if_inst[IMM12_HI]}}, if_inst[IMM12_HI:0]};
            default:
                w_imm = '0;
        endcase
    end

    // Load-use: only register fields the opcode actually reads can conflict
    assign w_hazard = ex_is_load && (ex_rd != '0) && !if_inst_invalid &&
                      ((uses_rs(w_op) && (w_rs == ex_rd)) ||
                       (uses_rt(w_op) && (w_rt == ex_rd)));

    // NOP never travels downstream as a valid instruction
    assign w_slot_valid = !if_inst_invalid && (w_op != OP_NOP);
    assign w_bubble     = flush || (!ex_hold && (w_hazard || !w_slot_valid));

    assign stall_out = (ex_hold | w_hazard) & ~flush & rst_n;

    // ID/EX register: flush/bubble clears, ex_hold freezes, else load decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_op        <= '0;
            r_rd        <= '0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_branch    <= 1'b0;
            r_jump      <= 1'b0;
        end else if (w_bubble) begin
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_op        <= '0;
            r_rd        <= '0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_branch    <= 1'b0;
            r_jump      <= 1'b0;
        end else if (!ex_hold) begin
            r_valid     <= 1'b1;
            r_pc        <= if_pc;
            r_op        <= w_op;
            r_rd        <= w_rd;
            r_rs        <= w_rs;
            r_rt        <= w_rt;
            r_rs_data   <= w_rs_data;
            r_rt_data   <= w_rt_data;
            r_imm       <= w_imm;
            r_reg_write <= writes_reg(w_op) && (w_rd != '0);
            r_mem_read  <= (w_op == OP_LW);
            r_mem_write <= (w_op == OP_SW);
            r_branch    <= (w_op == OP_BEQ) || (w_op == OP_BNE);
            r_jump      <= (w_op == OP_JMP) || (w_op == OP_JR);
        end
    end

    assign id_valid     = r_valid;
    assign id_pc        = r_pc;
    assign id_op        = r_op;
    assign id_rd        = r_rd;
    assign id_rs        = r_rs;
    assign id_rt        = r_rt;
    assign id_rs_data   = r_rs_data;
    assign id_rt_data   = r_rt_data;
    assign id_imm       = r_imm;
    assign id_reg_write = r_reg_write;
    assign id_mem_read  = r_mem_read;
    assign id_mem_write = r_mem_write;
    assign id_branch    = r_branch;
    assign id_jump      = r_jump;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode_stage
//  Brief    : Self-checking bench for decode_stage with a behavioural model of
//             the ID/EX bundle and directed instruction vectors.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] if_pc;
    logic [15:0] if_inst;
    logic        if_inst_invalid;
    logic        flush;
    logic        ex_hold;
    logic [2:0]  ex_rd;
    logic        ex_is_load;
    logic        wb_we;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        stall_out;
    logic        id_valid;
    logic [15:0] id_pc;
    logic [3:0]  id_op;
    logic [2:0]  id_rd, id_rs, id_rt;
    logic [15:0] id_rs_data, id_rt_data, id_imm;
    logic        id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump;

    int errors = 0;
    int checks = 0;

    decode_stage #(.NREGS(8), .AW(3)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .if_pc           (if_pc),
        .if_inst         (if_inst),
        .if_inst_invalid (if_inst_invalid),
        .flush           (flush),
        .ex_hold         (ex_hold),
        .ex_rd           (ex_rd),
        .ex_is_load      (ex_is_load),
        .wb_we           (wb_we),
        .wb_addr         (wb_addr),
        .wb_data         (wb_data),
        .stall_out       (stall_out),
        .id_valid        (id_valid),
        .id_pc           (id_pc),
        .id_op           (id_op),
        .id_rd           (id_rd),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_rs_data      (id_rs_data),
        .id_rt_data      (id_rt_data),
        .id_imm          (id_imm),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .id_mem_write    (id_mem_write),
        .id_branch       (id_branch),
        .id_jump         (id_jump)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] mrf [8];
    logic        m_valid = 1'b0;
    logic [15:0] m_pc, m_rs_data, m_rt_data, m_imm;
    logic [3:0]  m_op;
    logic [2:0]  m_rd, m_rs, m_rt;
    logic        m_rw, m_mr, m_mw, m_br, m_jp, m_urs, m_urt, m_uimm;

    function automatic bit reads_a(input int op);
        return (op <= 9) || op == 11 || op == 12 || op == 14;
    endfunction

    function automatic bit reads_b(input int op);
        return (op <= 6) || op == 9 || op == 11 || op == 12;
    endfunction

    function automatic bit has_imm(input int op);
        return (op >= 7 && op <= 13 && op != 8) || op == 8;
    endfunction

    function automatic logic [15:0] imm_of(input logic [15:0] inst);
        int op;
        int v;
        logic [15:0] r;
        op = int'(inst[15:12]);
        v = 0;
        if (op == 7 || op == 8 || op == 9 || op == 11 || op == 12) begin
            v = int'(inst[5:0]);
            if (v >= 32) v = v - 64;
        end else if (op == 10) begin
            v = int'(inst[8:0]) * 128;
        end else if (op == 13) begin
            v = int'(inst[11:0]);
            if (v >= 2048) v = v - 4096;
        end
        r = v[15:0];
        return r;
    endfunction

    function automatic logic [15:0] rd_reg(input logic [2:0] a);
        if (a == 3'd0) return 16'h0;
        if (wb_we && wb_addr == a) return wb_data;
        return mrf[a];
    endfunction

    function automatic bit hazard_now();
        int op;
        op = int'(if_inst[15:12]);
        return ex_is_load && ex_rd != 3'd0 && !if_inst_invalid &&
               ((reads_a(op) && if_inst[8:6] == ex_rd) ||
                (reads_b(op) && if_inst[5:3] == ex_rd));
    endfunction

    // Model of the ID/EX bundle and register contents
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
        end else begin
            if (flush) begin
                m_valid <= 1'b0;
            end else if (!ex_hold) begin
                if (hazard_now() || if_inst_invalid || if_inst[15:12] == 4'hF) begin
                    m_valid <= 1'b0;
                end else begin
                    m_valid   <= 1'b1;
                    m_pc      <= if_pc;
                    m_op      <= if_inst[15:12];
                    m_rd      <= if_inst[11:9];
                    m_rs      <= if_inst[8:6];
                    m_rt      <= if_inst[5:3];
                    m_rs_data <= rd_reg(if_inst[8:6]);
                    m_rt_data <= rd_reg(if_inst[5:3]);
                    m_imm     <= imm_of(if_inst);
                    m_urs     <= reads_a(int'(if_inst[15:12]));
                    m_urt     <= reads_b(int'(if_inst[15:12]));
                    m_uimm    <= has_imm(int'(if_inst[15:12]));
                    m_rw      <= (if_inst[15:12] <= 4'd8 || if_inst[15:12] == 4'hA) && if_inst[11:9] != 3'd0;
                    m_mr      <= if_inst[15:12] == 4'h8;
                    m_mw      <= if_inst[15:12] == 4'h9;
                    m_br      <= if_inst[15:12] == 4'hB || if_inst[15:12] == 4'hC;
                    m_jp      <= if_inst[15:12] == 4'hD || if_inst[15:12] == 4'hE;
                end
            end
            if (wb_we && wb_addr != 3'd0) mrf[wb_addr] <= wb_data;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("m_stall", stall_out, (ex_hold || hazard_now()) && !flush && rst_n);
        chk("m_valid", id_valid, m_valid);
        if (m_valid) begin
            chk("m_pc", id_pc, m_pc);
            chk("m_op", id_op, m_op);
            chk("m_rd", id_rd, m_rd);
            chk("m_rs", id_rs, m_rs);
            chk("m_rt", id_rt, m_rt);
            if (m_urs)  chk("m_rs_data", id_rs_data, m_rs_data);
            if (m_urt)  chk("m_rt_data", id_rt_data, m_rt_data);
            if (m_uimm) chk("m_imm", id_imm, m_imm);
            chk("m_reg_write", id_reg_write, m_rw);
            chk("m_mem_read", id_mem_read, m_mr);
            chk("m_mem_write", id_mem_write, m_mw);
            chk("m_branch", id_branch, m_br);
            chk("m_jump", id_jump, m_jp);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] pc, input logic [15:0] inst);
        if_pc = pc;
        if_inst = inst;
        if_inst_invalid = 1'b0;
    endtask

    task automatic idle();
        if_inst = 16'hF000;
        if_inst_invalid = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; if_pc = 16'h0; if_inst = 16'hF000; if_inst_invalid = 1'b1;
        flush = 1'b0; ex_hold = 1'b0; ex_rd = 3'd0; ex_is_load = 1'b0;
        wb_we = 1'b0; wb_addr = 3'd0; wb_data = 16'h0;
        repeat (3) step();
        chk("rst_valid", id_valid, 16'h0);
        chk("rst_pc", id_pc, 16'h0);
        chk("rst_stall", stall_out, 16'h0);

        rst_n = 1'b1;
        step();
        chk("post_rst_valid", id_valid, 16'h0);

        // ADDI r1,r0,5
        drive(16'h0010, 16'h7205);
        step();
        chk("addi_valid", id_valid, 16'h1);
        chk("addi_op", id_op, 16'h7);
        chk("addi_rd", id_rd, 16'h1);
        chk("addi_rs_data", id_rs_data, 16'h0);
        chk("addi_imm", id_imm, 16'h0005);
        chk("addi_rw", id_reg_write, 16'h1);

        // Preload r1..r7 with i*0x1111
        idle();
        for (int i = 1; i < 8; i++) begin
            wb_we = 1'b1; wb_addr = 3'(i); wb_data = 16'(i * 16'h1111);
            step();
        end
        wb_we = 1'b0;

        // ADD r3,r2,r2 with simultaneous writeback of r2 (bypass)
        drive(16'h0020, 16'h0690);
        wb_we = 1'b1; wb_addr = 3'd2; wb_data = 16'hBEEF;
        step();
        chk("byp_rs", id_rs_data, 16'hBEEF);
        chk("byp_rt", id_rt_data, 16'hBEEF);
        chk("byp_rd", id_rd, 16'h3);

        // ADD r4,r0,r0 with writeback to r0 (ignored)
        drive(16'h0022, 16'h0800);
        wb_addr = 3'd0; wb_data = 16'h1234;
        step();
        chk("r0_byp_rs", id_rs_data, 16'h0);
        chk("r0_byp_rt", id_rt_data, 16'h0);
        wb_we = 1'b0;
        step();
        chk("r0_rd", id_rs_data, 16'h0);

        // Load-use: SUB r5,r4,r1 while LW r4 in EX
        drive(16'h0024, 16'h1B08);
        ex_is_load = 1'b1; ex_rd = 3'd4;
        #1 chk("lu_stall", stall_out, 16'h1);
        step();
        chk("lu_bubble", id_valid, 16'h0);
        ex_is_load = 1'b0;
        step();
        chk("lu_valid", id_valid, 16'h1);
        chk("lu_op", id_op, 16'h1);
        chk("lu_rs_data", id_rs_data, 16'h4444);
        chk("lu_rt_data", id_rt_data, 16'h1111);

        // ADDI r1,r2,0x20: rt field equals ex_rd but rt is unused -> no stall
        drive(16'h0026, 16'h72A0);
        ex_is_load = 1'b1; ex_rd = 3'd4;
        #1 chk("nohz_stall", stall_out, 16'h0);
        step();
        chk("nohz_imm", id_imm, 16'hFFE0);
        // ex_rd = 0 never hazards
        drive(16'h0028, 16'h0200);
        ex_rd = 3'd0;
        #1 chk("rd0_stall", stall_out, 16'h0);
        step();
        ex_is_load = 1'b0;

        // ex_hold for 3 cycles with XOR r6,r1,r2 in ID
        drive(16'h0030, 16'h4C50);
        step();
        chk("xor_rt_data", id_rt_data, 16'hBEEF);
        ex_hold = 1'b1;
        drive(16'h0032, 16'h0690);
        for (int i = 0; i < 3; i++) begin
            #1 chk("hold_stall", stall_out, 16'h1);
            step();
            chk("hold_pc", id_pc, 16'h0030);
            chk("hold_op", id_op, 16'h4);
        end
        ex_hold = 1'b0;
        step();
        chk("release_pc", id_pc, 16'h0032);

        // Flush beats ex_hold and load-use
        drive(16'h0040, 16'h1B08);
        ex_hold = 1'b1; ex_is_load = 1'b1; ex_rd = 3'd4; flush = 1'b1;
        #1 chk("flush_stall", stall_out, 16'h0);
        step();
        chk("flush_valid", id_valid, 16'h0);
        ex_hold = 1'b0; ex_is_load = 1'b0; ex_rd = 3'd0; flush = 1'b0;

        // Branch / jump immediates
        drive(16'h0050, 16'hB07E);
        step();
        chk("beq_imm", id_imm, 16'hFFFE);
        chk("beq_branch", id_branch, 16'h1);
        chk("beq_jump", id_jump, 16'h0);
        drive(16'h0052, 16'hD800);
        step();
        chk("jmp_imm", id_imm, 16'hF800);
        chk("jmp_jump", id_jump, 16'h1);
        chk("jmp_branch", id_branch, 16'h0);

        // Assorted ops: LUI, LW, SW, JR, NOP, ADD rd=0, invalid slot
        drive(16'h0060, 16'hAFFF); step();
        chk("lui_imm", id_imm, 16'hFF80);
        drive(16'h0062, 16'h84C1); step();
        chk("lw_mr", id_mem_read, 16'h1);
        drive(16'h0064, 16'h90D1); step();
        chk("sw_mw", id_mem_write, 16'h1);
        drive(16'h0066, 16'hE0C0); step();
        drive(16'h0068, 16'hF000); step();
        chk("nop_valid", id_valid, 16'h0);
        drive(16'h006A, 16'h0050); step();
        chk("rd0_rw", id_reg_write, 16'h0);
        for (int op = 2; op < 13; op++) begin
            drive(16'(16'h0070 + op), 16'(op * 4096 + 16'h0A58));
            step();
        end
        drive(16'h0080, 16'h7205);
        if_inst_invalid = 1'b1;
        step();
        chk("inv_valid", id_valid, 16'h0);

        // Asynchronous reset mid-stream
        drive(16'h0090, 16'h7205);
        step();
        #1 rst_n = 1'b0;
        #1 chk("async_rst_valid", id_valid, 16'h0);
        chk("async_rst_pc", id_pc, 16'h0);
        idle();
        step();
        rst_n = 1'b1;
        step();
        chk("rst2_valid", id_valid, 16'h0);
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
